// File: rtl/pattern_subframe_sched_if.sv
// Pattern FIFO, imager loader and FSMIND handshake signals of the subframe scheduler.
// master = scheduler side, slave = FIFO/imager side.
interface pattern_subframe_sched_if #(
    parameter int unsigned DATA_W = 16
);
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic [DATA_W-1:0] ld_data;
    logic              ld_valid;
    logic              ld_row_last;
    logic              fsmind1;
    logic              fsmind1_ack;
    logic              fsmind0;
    logic              fsmind0_ack;

    modport master (
        output fifo_rd_en, ld_data, ld_valid, ld_row_last, fsmind1, fsmind0_ack,
        input  fifo_dout, fifo_empty, fsmind1_ack, fsmind0
    );

    modport slave (
        input  fifo_rd_en, ld_data, ld_valid, ld_row_last, fsmind1, fsmind0_ack,
        output fifo_dout, fifo_empty, fsmind1_ack, fsmind0
    );
endinterface

// File: rtl/pattern_subframe_sched.sv
// Per-subframe coded-exposure pattern sequencer: FIFO -> imager loader, then FSMIND1/FSMIND0 handshakes.
// Optional handshake timeout enabled by defining PAT_SCHED_HS_TIMEOUT_EN.
module pattern_subframe_sched #(
    parameter int unsigned ROWS          = 160,
    parameter int unsigned WORDS_PER_ROW = 18,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned NPAT_W        = 8,
    parameter int unsigned UNDERRUN_TO   = 1024,
    parameter int unsigned HS_TO         = 32'd1 << 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NPAT_W-1:0]      num_pat,
    input  logic [31:0]            exposure,
    pattern_subframe_sched_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic [NPAT_W-1:0]      subframe_cnt,
    output logic [1:0]             err
);
    localparam int unsigned WORDS = ROWS * WORDS_PER_ROW;
    localparam int unsigned WC_W  = $clog2(WORDS + 1);
    localparam int unsigned COL_W = $clog2(WORDS_PER_ROW);
    localparam int unsigned UR_W  = $clog2(UNDERRUN_TO + 1);

    typedef enum logic [2:0] {IDLE, LOAD, REQ, EXPOSE, WAIT0, ACK0, FIN} state_t;

    state_t            state;
    logic [NPAT_W-1:0] npat_q;
    logic [31:0]       exposure_q;
    logic [31:0]       exp_cnt;
    logic [WC_W-1:0]   req_cnt;
    logic [COL_W-1:0]  col_cnt;
    logic [UR_W-1:0]   ur_cnt;
    logic              fsmind1_r;
    logic              fsmind0_ack_r;
    logic              ld_valid_r;
    logic              ld_row_last_r;
    logic              rd_en_c;
    logic              words_left_c;

    // FIFO reads are issued straight from the empty flag so no word is lost to a stale flag
    assign words_left_c   = (req_cnt != WC_W'(WORDS));
    assign rd_en_c        = (state == LOAD) && !bus.fifo_empty && words_left_c;
    assign bus.fifo_rd_en = rd_en_c;
    assign bus.ld_data    = ld_valid_r ? bus.fifo_dout : DATA_W'(0);
    assign bus.ld_valid   = ld_valid_r;
    assign bus.ld_row_last = ld_row_last_r;
    assign bus.fsmind1    = fsmind1_r;
    assign bus.fsmind0_ack = fsmind0_ack_r;

`ifdef PAT_SCHED_HS_TIMEOUT_EN
    localparam int unsigned HS_W = $clog2(HS_TO + 1);
    logic [HS_W-1:0] hs_cnt;
    logic            hs_hold_c;

    // High while a handshake state will not be left this cycle
    assign hs_hold_c = ((state == REQ)   && !bus.fsmind1_ack) ||
                       ((state == WAIT0) && !bus.fsmind0)     ||
                       ((state == ACK0)  &&  bus.fsmind0);
`else
    if (HS_TO == 0) begin : g_hs_to_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            npat_q        <= '0;
            exposure_q    <= '0;
            exp_cnt       <= '0;
            req_cnt       <= '0;
            col_cnt       <= '0;
            ur_cnt        <= '0;
            fsmind1_r     <= 1'b0;
            fsmind0_ack_r <= 1'b0;
            ld_valid_r    <= 1'b0;
            ld_row_last_r <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            subframe_cnt  <= '0;
            err           <= '0;
`ifdef PAT_SCHED_HS_TIMEOUT_EN
            hs_cnt        <= '0;
`endif
        end else begin
            done          <= 1'b0;
            ld_valid_r    <= rd_en_c;
            ld_row_last_r <= rd_en_c && (col_cnt == COL_W'(WORDS_PER_ROW - 1));
            if (rd_en_c) begin
                req_cnt <= req_cnt + WC_W'(1);
                col_cnt <= (col_cnt == COL_W'(WORDS_PER_ROW - 1)) ? '0 : col_cnt + COL_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        err <= '0;
                        if (num_pat == '0) begin
                            done <= 1'b1;
                        end else begin
                            npat_q       <= num_pat;
                            exposure_q   <= exposure;
                            subframe_cnt <= '0;
                            req_cnt      <= '0;
                            col_cnt      <= '0;
                            ur_cnt       <= '0;
                            busy         <= 1'b1;
                            state        <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (!words_left_c && ld_valid_r) begin
                        fsmind1_r <= 1'b1;
                        state     <= REQ;
                    end else if (rd_en_c) begin
                        ur_cnt <= '0;
                    end else if (words_left_c) begin
                        // Starved too long: abandon the sequence
                        if (ur_cnt == UR_W'(UNDERRUN_TO - 1)) begin
                            err[0] <= 1'b1;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            ur_cnt <= ur_cnt + UR_W'(1);
                        end
                    end
                end
                REQ: begin
                    if (bus.fsmind1_ack) begin
                        fsmind1_r <= 1'b0;
                        exp_cnt   <= exposure_q;
                        state     <= EXPOSE;
                    end
                end
                EXPOSE: begin
                    if (exp_cnt == 32'd0) state <= WAIT0;
                    else                  exp_cnt <= exp_cnt - 32'd1;
                end
                WAIT0: begin
                    if (bus.fsmind0) begin
                        fsmind0_ack_r <= 1'b1;
                        state         <= ACK0;
                    end
                end
                ACK0: begin
                    if (!bus.fsmind0) begin
                        fsmind0_ack_r <= 1'b0;
                        subframe_cnt  <= subframe_cnt + NPAT_W'(1);
                        if ((subframe_cnt + NPAT_W'(1)) == npat_q) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            req_cnt <= '0;
                            col_cnt <= '0;
                            ur_cnt  <= '0;
                            state   <= LOAD;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

`ifdef PAT_SCHED_HS_TIMEOUT_EN
            // Timeout overrides whatever the handshake state scheduled above
            if (hs_hold_c) begin
                if (hs_cnt == HS_W'(HS_TO - 1)) begin
                    err[1]        <= 1'b1;
                    fsmind1_r     <= 1'b0;
                    fsmind0_ack_r <= 1'b0;
                    busy          <= 1'b0;
                    hs_cnt        <= '0;
                    state         <= IDLE;
                end else begin
                    hs_cnt <= hs_cnt + HS_W'(1);
                end
            end else begin
                hs_cnt <= '0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_pattern_subframe_sched.sv
// Directed bench for pattern_subframe_sched: FIFO model, imager responder and loader-word scoreboard.
module tb_pattern_subframe_sched;
    localparam int unsigned WORDS = 2880;
    localparam int unsigned WPR   = 18;
    localparam int unsigned DEPTH = 16384;
`ifdef PAT_SCHED_HS_TIMEOUT_EN
    localparam int unsigned TB_HS_TO = 4096;
`else
    localparam int unsigned TB_HS_TO = 32'd1 << 20;
`endif

    typedef struct packed {
        logic [15:0] d;
        logic        rl;
    } wrd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  num_pat = '0;
    logic [31:0] exposure = '0;
    logic        busy, done;
    logic [7:0]  subframe_cnt;
    logic [1:0]  err;

    pattern_subframe_sched_if #(.DATA_W(16)) ifc ();

    pattern_subframe_sched #(.HS_TO(TB_HS_TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_pat      (num_pat),
        .exposure     (exposure),
        .bus          (ifc),
        .busy         (busy),
        .done         (done),
        .subframe_cnt (subframe_cnt),
        .err          (err)
    );

    always #5 clk = ~clk;

    // FIFO model: words become visible via avail (every 4th cycle in drip mode)
    logic [15:0] mem [DEPTH];
    int wptr = 0, rptr = 0, avail = 0, dcnt = 0;
    bit drip = 1'b0, fifo_flush = 1'b0;
    assign ifc.fifo_empty = (rptr == avail);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rptr  <= wptr;
            avail <= wptr;
        end else begin
            if (ifc.fifo_rd_en) begin
                ifc.fifo_dout <= mem[rptr % DEPTH];
                rptr <= rptr + 1;
            end
            if (!drip) begin
                avail <= wptr;
            end else if (dcnt == 3) begin
                dcnt <= 0;
                if (avail < wptr) avail <= avail + 1;
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end

    // Monitor: captures loader words and event counts
    wrd_t obs_q[$];
    wrd_t exp_q[$];
    int ld_cnt = 0, rl_cnt = 0, done_cnt = 0, f1_cnt = 0, rd_cnt = 0;
    logic f1_prev = 1'b0;

    always @(negedge clk) begin
        if (ifc.ld_valid) begin
            obs_q.push_back({ifc.ld_data, ifc.ld_row_last});
            ld_cnt <= ld_cnt + 1;
            if (ifc.ld_row_last) rl_cnt <= rl_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (ifc.fifo_rd_en) rd_cnt <= rd_cnt + 1;
        if (ifc.fsmind1 && !f1_prev) f1_cnt <= f1_cnt + 1;
        f1_prev <= ifc.fsmind1;
    end

    int n_tests = 0, n_fail = 0;
    int pat_word = 0;
    int b_ld, b_rl, b_done, b_f1, b_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_words(input int n, input bit seq, input int base);
        for (int i = 0; i < n; i++) begin
            logic [15:0] w;
            w = seq ? 16'(base + i) : 16'($urandom);
            mem[wptr % DEPTH] = w;
            exp_q.push_back({w, (pat_word % WPR) == (WPR - 1)});
            pat_word = (pat_word == WORDS - 1) ? 0 : pat_word + 1;
            wptr++;
        end
    endtask

    task automatic drain(input string tag);
        while (obs_q.size() > 0) begin
            wrd_t o, e;
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                check({tag, "_unexpected_word"}, 32'(o.d), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_ld_data"}, 32'(o.d), 32'(e.d));
                check({tag, "_row_last"}, 32'(o.rl), 32'(e.rl));
            end
        end
    endtask

    task automatic flush_fifo();
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
        exp_q.delete();
        pat_word = 0;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return ifc.fsmind1;
            1:       return ifc.fsmind0_ack;
            2:       return busy;
            default: return done;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic val, input int max, input string tag);
        int i = 0;
        while (sig(sel) !== val && i < max) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(sig(sel)), 32'(val));
    endtask

    task automatic start_seq(input logic [7:0] np, input logic [31:0] ex);
        @(negedge clk);
        start = 1'b1; num_pat = np; exposure = ex;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic imager_subframe(input int ack_dly, input int f0_dly, input int f1_bound);
        wait_for(0, 1'b1, f1_bound, "fsmind1_rise");
        repeat (ack_dly) @(negedge clk);
        ifc.fsmind1_ack = 1'b1;
        wait_for(0, 1'b0, 10, "fsmind1_fall");
        ifc.fsmind1_ack = 1'b0;
        repeat (f0_dly) @(negedge clk);
        ifc.fsmind0 = 1'b1;
        wait_for(1, 1'b1, 3000, "fsmind0_ack_rise");
        ifc.fsmind0 = 1'b0;
        wait_for(1, 1'b0, 10, "fsmind0_ack_fall");
    endtask

    task automatic snap();
        b_ld = ld_cnt; b_rl = rl_cnt; b_done = done_cnt; b_f1 = f1_cnt; b_rd = rd_cnt;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.fsmind1_ack = 1'b0;
        ifc.fsmind0     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_outputs", 32'({ifc.fsmind1, ifc.fsmind0_ack, ifc.ld_valid, ifc.ld_row_last, ifc.fifo_rd_en}), 0);
        check("rst_subframe_cnt", 32'(subframe_cnt), 0);
        check("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single subframe, prefilled FIFO with counting data
        pat_word = 0;
        push_words(WORDS, 1'b1, 0);
        repeat (2) @(negedge clk);
        snap();
        start_seq(8'd1, 32'd20);
        imager_subframe(1000, 2000, 4000);
        repeat (4) @(negedge clk);
        drain("t1");
        check("t1_ld_valid_count", 32'(ld_cnt - b_ld), WORDS);
        check("t1_row_last_count", 32'(rl_cnt - b_rl), 160);
        check("t1_done_count", 32'(done_cnt - b_done), 1);
        check("t1_fsmind1_pulses", 32'(f1_cnt - b_f1), 1);
        check("t1_subframe_cnt", 32'(subframe_cnt), 1);
        check("t1_err", 32'(err), 0);
        check("t1_busy", 32'(busy), 0);
        check("t1_sb_empty", 32'(exp_q.size()), 0);

        // num_pat = 0: immediate done, no FIFO reads even with data present
        push_words(5, 1'b0, 0);
        repeat (2) @(negedge clk);
        snap();
        @(negedge clk);
        start = 1'b1; num_pat = 8'd0; exposure = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("np0_done_next_cycle", 32'(done), 1);
        check("np0_busy", 32'(busy), 0);
        @(negedge clk);
        check("np0_done_one_cycle", 32'(done), 0);
        repeat (5) @(negedge clk);
        check("np0_no_fifo_reads", 32'(rd_cnt - b_rd), 0);
        check("np0_done_count", 32'(done_cnt - b_done), 1);
        flush_fifo();

        // Three subframes with FIFO drip-fed every 4th cycle
        drip = 1'b1;
        push_words(3 * WORDS, 1'b0, 0);
        snap();
        start_seq(8'd3, 32'd7);
        for (int s = 0; s < 3; s++) begin
            imager_subframe(3, 30, 13000);
            if (s == 1) check("t2_no_done_before_last", 32'(done_cnt - b_done), 0);
        end
        repeat (4) @(negedge clk);
        drain("t2");
        drip = 1'b0;
        check("t2_fsmind1_pulses", 32'(f1_cnt - b_f1), 3);
        check("t2_done_count", 32'(done_cnt - b_done), 1);
        check("t2_subframe_cnt", 32'(subframe_cnt), 3);
        check("t2_ld_valid_count", 32'(ld_cnt - b_ld), 3 * WORDS);
        check("t2_sb_empty", 32'(exp_q.size()), 0);

        // FIFO underrun after 100 words
        pat_word = 0;
        push_words(100, 1'b0, 0);
        snap();
        start_seq(8'd1, 32'd0);
        wait_for(2, 1'b0, 1500, "ur_busy_fall");
        repeat (2) @(negedge clk);
        drain("ur");
        check("ur_err", 32'(err), 1);
        check("ur_no_done", 32'(done_cnt - b_done), 0);
        check("ur_ld_count", 32'(ld_cnt - b_ld), 100);
        check("ur_no_fsmind1", 32'(ifc.fsmind1), 0);

        // Next start clears err and runs cleanly
        pat_word = 0;
        push_words(WORDS, 1'b0, 0);
        snap();
        start_seq(8'd1, 32'd0);
        check("ur_err_cleared", 32'(err), 0);
        imager_subframe(0, 5, 4000);
        repeat (4) @(negedge clk);
        drain("ur2");
        check("ur2_done_count", 32'(done_cnt - b_done), 1);
        check("ur2_err", 32'(err), 0);

        // Reset during EXPOSE of subframe 2
        pat_word = 0;
        push_words(2 * WORDS, 1'b0, 0);
        start_seq(8'd3, 32'd2000);
        imager_subframe(2, 2010, 4000);
        wait_for(0, 1'b1, 4000, "rs_fsmind1_rise2");
        ifc.fsmind1_ack = 1'b1;
        wait_for(0, 1'b0, 10, "rs_fsmind1_fall2");
        ifc.fsmind1_ack = 1'b0;
        repeat (10) @(negedge clk);
        check("rs_pre_busy", 32'(busy), 1);
        check("rs_pre_subframe_cnt", 32'(subframe_cnt), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rs_busy", 32'(busy), 0);
        check("rs_subframe_cnt", 32'(subframe_cnt), 0);
        check("rs_outputs", 32'({ifc.fsmind1, ifc.fsmind0_ack, ifc.ld_valid, ifc.ld_row_last, ifc.fifo_rd_en, done}), 0);
        check("rs_ld_data", 32'(ifc.ld_data), 0);
        check("rs_err", 32'(err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drain("rs");
        check("rs_sb_empty", 32'(exp_q.size()), 0);
        flush_fifo();

        push_words(WORDS, 1'b1, 100);
        snap();
        start_seq(8'd1, 32'd5);
        imager_subframe(1, 10, 4000);
        repeat (4) @(negedge clk);
        drain("rs2");
        check("rs2_done_count", 32'(done_cnt - b_done), 1);
        check("rs2_subframe_cnt", 32'(subframe_cnt), 1);
        check("rs2_err", 32'(err), 0);
        check("rs2_ld_count", 32'(ld_cnt - b_ld), WORDS);

        // fsmind1_ack never arrives
        pat_word = 0;
        push_words(WORDS, 1'b0, 0);
        snap();
        start_seq(8'd1, 32'd0);
        wait_for(0, 1'b1, 4000, "hs_fsmind1_rise");
`ifdef PAT_SCHED_HS_TIMEOUT_EN
        wait_for(2, 1'b0, TB_HS_TO + 20, "hs_busy_fall");
        check("hs_err", 32'(err), 2);
        check("hs_fsmind1_dropped", 32'(ifc.fsmind1), 0);
        check("hs_no_done", 32'(done_cnt - b_done), 0);
`else
        repeat (3000) @(negedge clk);
        check("hs_still_waiting", 32'(ifc.fsmind1), 1);
        check("hs_busy", 32'(busy), 1);
        check("hs_err", 32'(err), 0);
`endif
        drain("hs");
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
